// File: rtl/gpr_pkg.sv
// Shared types for the GPR write-port arbiter.
// Register sizes, state enum and the write-port bundle.
package gpr_pkg;

   localparam int XLEN = 64;
   localparam int NREG = 32;
   localparam int AW   = $clog2(NREG);
   localparam int CW   = 4;

   typedef logic [AW-1:0]   gpr_addr_t;
   typedef logic [XLEN-1:0] gpr_data_t;
   typedef logic [CW-1:0]   wait_cnt_t;

   typedef enum logic {
      IDLE = 1'b0,
      LOCK = 1'b1
   } arb_state_e;

   typedef struct packed {
      logic      wen;
      gpr_addr_t waddr;
      gpr_data_t wdata;
   } gpr_wr_t;

endpackage

// File: rtl/gpr_starve_ctr.sv
// Saturating count of consecutive stalled dbg cycles.
// Raises boost once the count reaches MAX_WAIT.
module gpr_starve_ctr
   import gpr_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic clk,
   input  logic rst,
   input  logic inc,
   input  logic clr,
   output logic boost
);

   localparam wait_cnt_t LIMIT = wait_cnt_t'(MAX_WAIT);
   localparam wait_cnt_t SAT   = '1;

   wait_cnt_t cnt;

   // count stalled cycles, saturating at all-ones
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (inc && (cnt != SAT)) begin
         cnt <= cnt + wait_cnt_t'(1);
      end
   end

   assign boost = (cnt >= LIMIT);

endmodule

// File: rtl/gpr_wport_arbiter.sv
// Arbitrates the single GPR write port between wb and dbg.
// wb has priority; dbg gets a starvation boost and a lock mode.
module gpr_wport_arbiter
   import gpr_pkg::*;
#(
   parameter int MAX_WAIT = 4
) (
   input  logic      clk,
   input  logic      rst,
   input  logic      wb_valid,
   output logic      wb_ready,
   input  gpr_addr_t wb_addr,
   input  gpr_data_t wb_data,
   input  logic      dbg_valid,
   output logic      dbg_ready,
   input  gpr_addr_t dbg_addr,
   input  gpr_data_t dbg_data,
   input  logic      dbg_lock,
   output logic      rf_wen,
   output gpr_addr_t rf_waddr,
   output gpr_data_t rf_wdata,
   output logic      dbg_forced,
   output logic      locked
);

   arb_state_e state;
   gpr_wr_t    wr_q;
   logic       boost;
   logic       wb_hs;
   logic       dbg_hs;
   logic       stall_inc;

   gpr_starve_ctr #(
      .MAX_WAIT (MAX_WAIT)
   ) u_starve (
      .clk   (clk),
      .rst   (rst),
      .inc   (stall_inc),
      .clr   (!stall_inc),
      .boost (boost)
   );

   // grant decision; nothing is ready while reset is held
   always_comb begin
      wb_ready   = 1'b0;
      dbg_ready  = 1'b0;
      dbg_forced = 1'b0;
      if (rst) begin
         unique case (state)
            LOCK: begin
               dbg_ready = dbg_valid;
            end
            IDLE: begin
               dbg_forced = dbg_valid && boost;
               dbg_ready  = dbg_valid && (!wb_valid || boost);
               wb_ready   = wb_valid && !dbg_ready;
            end
         endcase
      end
   end

   assign wb_hs     = wb_valid && wb_ready;
   assign dbg_hs    = dbg_valid && dbg_ready;
   assign stall_inc = dbg_valid && !dbg_ready;

   // register the winning beat; x0 writes are acked but not enabled
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_q <= '0;
      end else if (wb_hs) begin
         wr_q.wen   <= (wb_addr != '0);
         wr_q.waddr <= wb_addr;
         wr_q.wdata <= wb_data;
      end else if (dbg_hs) begin
         wr_q.wen   <= (dbg_addr != '0);
         wr_q.waddr <= dbg_addr;
         wr_q.wdata <= dbg_data;
      end else begin
         wr_q.wen <= 1'b0;
      end
   end

   // IDLE/LOCK state with a registered locked flag
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= IDLE;
         locked <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               if (dbg_hs && dbg_lock) begin
                  state  <= LOCK;
                  locked <= 1'b1;
               end
            end
            LOCK: begin
               if (!dbg_lock && (dbg_hs || !dbg_valid)) begin
                  state  <= IDLE;
                  locked <= 1'b0;
               end
            end
         endcase
      end
   end

   assign rf_wen   = wr_q.wen;
   assign rf_waddr = wr_q.waddr;
   assign rf_wdata = wr_q.wdata;

endmodule

// File: tb/tb_gpr_wport_arbiter.sv
// Bench for gpr_wport_arbiter: directed table, hand sequences,
// and random traffic against a rule-level reference model.
module tb_gpr_wport_arbiter;
   import gpr_pkg::*;

   localparam int MAX_WAIT = 4;

   logic      clk = 1'b0;
   logic      rst;
   logic      wb_valid, wb_ready;
   gpr_addr_t wb_addr;
   gpr_data_t wb_data;
   logic      dbg_valid, dbg_ready;
   gpr_addr_t dbg_addr;
   gpr_data_t dbg_data;
   logic      dbg_lock;
   logic      rf_wen;
   gpr_addr_t rf_waddr;
   gpr_data_t rf_wdata;
   logic      dbg_forced, locked;

   int pass_cnt  = 0;
   int total_cnt = 0;

   always #5 clk = ~clk;

   gpr_wport_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
      .clk        (clk),
      .rst        (rst),
      .wb_valid   (wb_valid),
      .wb_ready   (wb_ready),
      .wb_addr    (wb_addr),
      .wb_data    (wb_data),
      .dbg_valid  (dbg_valid),
      .dbg_ready  (dbg_ready),
      .dbg_addr   (dbg_addr),
      .dbg_data   (dbg_data),
      .dbg_lock   (dbg_lock),
      .rf_wen     (rf_wen),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .dbg_forced (dbg_forced),
      .locked     (locked)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   task automatic drive(input logic wv, input logic [4:0] wa,
                        input logic [63:0] wd, input logic dv,
                        input logic [4:0] da, input logic [63:0] dd,
                        input logic dl);
      wb_valid  = wv;
      wb_addr   = wa;
      wb_data   = wd;
      dbg_valid = dv;
      dbg_addr  = da;
      dbg_data  = dd;
      dbg_lock  = dl;
   endtask

   typedef struct {
      logic        wv;
      logic [4:0]  wa;
      logic [63:0] wd;
      logic        dv;
      logic [4:0]  da;
      logic [63:0] dd;
      logic        dl;
      logic        e_wr;
      logic        e_dr;
      logic        e_f;
      logic        e_wen;
      logic [4:0]  e_wa;
      logic [63:0] e_wd;
      logic        e_lk;
   } vec_t;

   function automatic vec_t mk(
      input logic wv, input int wa, input logic [63:0] wd,
      input logic dv, input int da, input logic [63:0] dd,
      input logic dl, input logic e_wr, input logic e_dr,
      input logic e_f, input logic e_wen, input int e_wa,
      input logic [63:0] e_wd, input logic e_lk);
      vec_t v;
      v.wv = wv; v.wa = 5'(wa); v.wd = wd;
      v.dv = dv; v.da = 5'(da); v.dd = dd; v.dl = dl;
      v.e_wr = e_wr; v.e_dr = e_dr; v.e_f = e_f;
      v.e_wen = e_wen; v.e_wa = 5'(e_wa); v.e_wd = e_wd;
      v.e_lk = e_lk;
      return v;
   endfunction

   vec_t tbl[18];

   // reference model state
   bit          m_lock;
   int          m_wait;
   bit          m_wen;
   logic [4:0]  m_wa;
   logic [63:0] m_wd;

   initial begin
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
      rst = 1'b0;

      // reset holds everything off even with a request pending
      #2;
      drive(1'b1, 5'd5, 64'h1234, 1'b0, 5'd0, 64'd0, 1'b0);
      @(posedge clk); #1;
      chk("rst_wb_ready", 64'(wb_ready), 64'd0);
      chk("rst_dbg_ready", 64'(dbg_ready), 64'd0);
      chk("rst_forced", 64'(dbg_forced), 64'd0);
      chk("rst_rf_wen", 64'(rf_wen), 64'd0);
      chk("rst_rf_waddr", 64'(rf_waddr), 64'd0);
      chk("rst_rf_wdata", 64'(rf_wdata), 64'd0);
      chk("rst_locked", 64'(locked), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      #1;
      chk("rel_wb_ready", 64'(wb_ready), 64'd1);
      @(posedge clk); #1;
      chk("rel_rf_wen", 64'(rf_wen), 64'd1);
      chk("rel_rf_waddr", 64'(rf_waddr), 64'd5);
      chk("rel_rf_wdata", 64'(rf_wdata), 64'h1234);

      // x0, starvation, lock burst, abandoned lock
      tbl[0] = mk(1, 0, 64'hDEAD, 0, 0, 0, 0, 1, 0, 0, 0, 0, 64'hDEAD, 0);
      for (int i = 0; i < 4; i++)
         tbl[1+i] = mk(1, 10+i, 64'(256+i), 1, 7, 64'hAA, 0,
                       1, 0, 0, 1, 10+i, 64'(256+i), 0);
      tbl[5] = mk(1, 14, 64'h104, 1, 7, 64'hAA, 0, 0, 1, 1, 1, 7, 64'hAA, 0);
      tbl[6] = mk(1, 14, 64'h104, 0, 0, 0, 0, 1, 0, 0, 1, 14, 64'h104, 0);
      for (int i = 0; i < 4; i++)
         tbl[7+i] = mk(1, 20+i, 64'(512+i), 1, 1, 64'h11, 1,
                       1, 0, 0, 1, 20+i, 64'(512+i), 0);
      tbl[11] = mk(1, 24, 64'h204, 1, 1, 64'h11, 1, 0, 1, 1, 1, 1, 64'h11, 1);
      tbl[12] = mk(1, 24, 64'h204, 1, 2, 64'h22, 1, 0, 1, 0, 1, 2, 64'h22, 1);
      tbl[13] = mk(1, 24, 64'h204, 1, 3, 64'h33, 0, 0, 1, 0, 1, 3, 64'h33, 0);
      tbl[14] = mk(1, 24, 64'h204, 0, 0, 0, 0, 1, 0, 0, 1, 24, 64'h204, 0);
      tbl[15] = mk(0, 0, 0, 1, 4, 64'h44, 1, 0, 1, 0, 1, 4, 64'h44, 1);
      tbl[16] = mk(1, 25, 64'h205, 0, 0, 0, 0, 0, 0, 0, 0, 4, 64'h44, 0);
      tbl[17] = mk(1, 25, 64'h205, 0, 0, 0, 0, 1, 0, 0, 1, 25, 64'h205, 0);

      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         drive(tbl[i].wv, tbl[i].wa, tbl[i].wd, tbl[i].dv,
               tbl[i].da, tbl[i].dd, tbl[i].dl);
         #1;
         chk($sformatf("t%0d_wb_ready", i), 64'(wb_ready), 64'(tbl[i].e_wr));
         chk($sformatf("t%0d_dbg_ready", i), 64'(dbg_ready), 64'(tbl[i].e_dr));
         chk($sformatf("t%0d_forced", i), 64'(dbg_forced), 64'(tbl[i].e_f));
         @(posedge clk); #1;
         chk($sformatf("t%0d_rf_wen", i), 64'(rf_wen), 64'(tbl[i].e_wen));
         chk($sformatf("t%0d_rf_waddr", i), 64'(rf_waddr), 64'(tbl[i].e_wa));
         chk($sformatf("t%0d_rf_wdata", i), 64'(rf_wdata), tbl[i].e_wd);
         chk($sformatf("t%0d_locked", i), 64'(locked), 64'(tbl[i].e_lk));
      end

      // asynchronous reset in the middle of a locked burst
      @(negedge clk);
      drive(1'b0, 5'd0, 64'd0, 1'b1, 5'd6, 64'h66, 1'b1);
      @(posedge clk); #1;
      chk("ml_locked", 64'(locked), 64'd1);
      @(negedge clk);
      drive(1'b1, 5'd9, 64'h99, 1'b1, 5'd7, 64'h77, 1'b1);
      @(posedge clk); #1;
      chk("ml_pending_wen", 64'(rf_wen), 64'd1);
      #2 rst = 1'b0;
      #1;
      chk("ml_async_wen", 64'(rf_wen), 64'd0);
      chk("ml_async_locked", 64'(locked), 64'd0);
      chk("ml_async_dbg_ready", 64'(dbg_ready), 64'd0);
      @(negedge clk);
      rst = 1'b1;
      drive(1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 64'd0, 1'b0);
      #1;
      chk("ml_after_wb_ready", 64'(wb_ready), 64'd1);
      @(posedge clk); #1;
      chk("ml_after_waddr", 64'(rf_waddr), 64'd9);
      chk("ml_after_locked", 64'(locked), 64'd0);

      // fresh reset, then random traffic against the model
      @(negedge clk);
      drive(1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 64'd0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      m_lock = 0; m_wait = 0; m_wen = 0; m_wa = '0; m_wd = '0;
      begin
         bit w_acc, d_acc, e_wr, e_dr, e_f, starving;
         w_acc = 1; d_acc = 1;
         for (int c = 0; c < 2000; c++) begin
            if (c != 0) @(negedge clk);
            if (!wb_valid || w_acc) begin
               wb_valid = ($urandom_range(0, 9) < 7);
               wb_addr  = gpr_addr_t'($urandom);
               wb_data  = {$urandom, $urandom};
            end
            if (!dbg_valid || d_acc) begin
               dbg_valid = ($urandom_range(0, 9) < 5);
               dbg_addr  = gpr_addr_t'($urandom);
               dbg_data  = {$urandom, $urandom};
               dbg_lock  = 1'($urandom_range(0, 1));
            end
            #1;
            starving = (m_wait >= MAX_WAIT);
            if (m_lock) begin
               e_dr = dbg_valid; e_wr = 0; e_f = 0;
            end else begin
               e_dr = dbg_valid && (!wb_valid || starving);
               e_wr = wb_valid && !e_dr;
               e_f  = dbg_valid && starving;
            end
            chk("rnd_wb_ready", 64'(wb_ready), 64'(e_wr));
            chk("rnd_dbg_ready", 64'(dbg_ready), 64'(e_dr));
            chk("rnd_forced", 64'(dbg_forced), 64'(e_f));
            w_acc = wb_valid && e_wr;
            d_acc = dbg_valid && e_dr;
            if (w_acc) begin
               m_wen = (wb_addr != 0); m_wa = wb_addr; m_wd = wb_data;
            end else if (d_acc) begin
               m_wen = (dbg_addr != 0); m_wa = dbg_addr; m_wd = dbg_data;
            end else begin
               m_wen = 0;
            end
            if (dbg_valid && !e_dr) m_wait = (m_wait < 15) ? m_wait + 1 : 15;
            else m_wait = 0;
            if (m_lock) m_lock = dbg_lock;
            else m_lock = d_acc && dbg_lock;
            @(posedge clk); #1;
            chk("rnd_rf_wen", 64'(rf_wen), 64'(m_wen));
            chk("rnd_rf_waddr", 64'(rf_waddr), 64'(m_wa));
            chk("rnd_rf_wdata", 64'(rf_wdata), m_wd);
            chk("rnd_locked", 64'(locked), 64'(m_lock));
         end
      end

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
